// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches a program from a small instruction memory and hands
// one instruction at a time to the execute stage; start-to-out_valid latency is
// 2 cycles and the presented fields hold while out_ready is low.
// Optional macro FETCH_LOOP_EN: after the last instruction, wrap pc to 0 and keep
// fetching until abort or reset; without it the unit halts in DONE.
module instr_fetch_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [17:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  output logic [1:0]    opcode,
  output logic [7:0]    operand1,
  output logic [7:0]    operand2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [7:0]    issued_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    issued_q, issued_d;
  logic [17:0]   instr_q;
  logic [17:0]   mem [DEPTH];
  logic [AW:0]   len_sat;
  logic          last;

  // Program lengths beyond the memory size are clamped so pc never runs past the end.
  assign len_sat = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign last    = ({1'b0, pc_q} == (len_q - LEN_ONE));

  // Instruction memory: not reset; writes only land while no program is running.
  always_ff @(posedge clk) begin
    if (prog_we && ((state_q == IDLE) || (state_q == DONE))) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Instruction register: loaded in FETCH, untouched in PRESENT so fields hold under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= '0;
    end else if (state_q == FETCH) begin
      instr_q <= mem[pc_q];
    end
  end

  // State, pc, length and issue-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      issued_q <= issued_d;
    end
  end

  // Next-state logic; abort overrides everything, including an accept in the same cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    issued_d = issued_q;
    if (abort) begin
      state_d = IDLE;
      pc_d    = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_d    = len_sat;
            pc_d     = '0;
            issued_d = '0;
            state_d  = (prog_len != '0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          state_d = PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            issued_d = issued_q + 8'd1;
            if (last) begin
`ifdef FETCH_LOOP_EN
              pc_d    = '0;
              state_d = FETCH;
`else
              state_d = DONE;
`endif
            end else begin
              pc_d    = pc_q + PC_ONE;
              state_d = FETCH;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign opcode     = instr_q[17:16];
  assign operand1   = instr_q[15:8];
  assign operand2   = instr_q[7:0];
  assign out_valid  = (state_q == PRESENT);
  assign busy       = (state_q == FETCH) || (state_q == PRESENT);
  assign done       = (state_q == DONE);
  assign pc         = pc_q;
  assign issued_cnt = issued_q;

endmodule
